// File: rtl/demux12_stream_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer: default widths and
// the per-output FIFO geometry.
package demux12_stream_pkg;

    localparam int DEF_SIZE   = 8;
    localparam int DEF_CNTW   = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/demux12_stream_if.sv
// Producer-side stream, two consumer-side streams and the transfer counters.
// Handshake: a word moves on a rising edge exactly when valid & ready are both
// high; valid never waits on ready, and data is held while valid is unanswered.
interface demux12_stream_if #(
    parameter int Size = 8,
    parameter int CntW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic            s;
    logic [Size-1:0] d;
    logic            y0_valid;
    logic            y0_ready;
    logic [Size-1:0] y0;
    logic            y1_valid;
    logic            y1_ready;
    logic [Size-1:0] y1;
    logic [CntW-1:0] cnt0;
    logic [CntW-1:0] cnt1;

    modport slave (
        input  in_valid, s, d, y0_ready, y1_ready,
        output in_ready, y0_valid, y0, y1_valid, y1, cnt0, cnt1
    );

    modport master (
        output in_valid, s, d, y0_ready, y1_ready,
        input  in_ready, y0_valid, y0, y1_valid, y1, cnt0, cnt1
    );
endinterface

// File: rtl/demux12_stream_fifo2.sv
// Two-entry FIFO with registered full/valid flags; output reads 0 when empty.
module demux12_stream_fifo2
    import demux12_stream_pkg::*;
#(
    parameter int Size = DEF_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic [Size-1:0] din_i,
    input  logic            pop_i,
    output logic [Size-1:0] dout_o,
    output logic            valid_o,
    output logic            full_o
);
    logic [Size-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == OCC_W'(FIFO_DEPTH));
    assign dout_o  = valid_o ? mem_q[rd_q] : '0;

    // A full FIFO refuses pushes even when it pops in the same cycle.
    always_comb begin
        do_push = push_i & ~full_o;
        do_pop  = pop_i & valid_o;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/demux12_stream.sv
// Registered 1-to-2 stream demux: each accepted word goes to the FIFO picked by
// s at the accepting edge; each output counts its completed transfers.
module demux12_stream
    import demux12_stream_pkg::*;
#(
    parameter int Size = DEF_SIZE,
    parameter int CntW = DEF_CNTW
) (
    input logic               clk,
    input logic               rst,
    demux12_stream_if.slave   bus
);
    logic            full0, full1;
    logic            accept, push0, push1, pop0, pop1;
    logic [CntW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Ready looks only at the selected FIFO's registered full flag.
    assign bus.in_ready = ~rst & (bus.s ? ~full1 : ~full0);

    always_comb begin
        accept = bus.in_valid & bus.in_ready;
        push0  = accept & ~bus.s;
        push1  = accept & bus.s;
        pop0   = bus.y0_valid & bus.y0_ready;
        pop1   = bus.y1_valid & bus.y1_ready;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (pop0) cnt0_d = cnt0_q + 1'b1;
        if (pop1) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;

    demux12_stream_fifo2 #(.Size(Size)) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push0),
        .din_i   (bus.d),
        .pop_i   (pop0),
        .dout_o  (bus.y0),
        .valid_o (bus.y0_valid),
        .full_o  (full0)
    );

    demux12_stream_fifo2 #(.Size(Size)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push1),
        .din_i   (bus.d),
        .pop_i   (pop1),
        .dout_o  (bus.y1),
        .valid_o (bus.y1_valid),
        .full_o  (full1)
    );
endmodule

// File: tb/tb_demux12_stream.sv
// Bench for demux12_stream: directed scenarios plus a random soak, checked by
// a negedge monitor against per-output expected queues.
module tb_demux12_stream;
    localparam int W = 8;
    localparam int C = 8;

    logic clk;
    logic rst;

    demux12_stream_if #(.Size(W), .CntW(C)) bus ();

    demux12_stream #(.Size(W), .CntW(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [C-1:0] exp_cnt0;
    logic [C-1:0] exp_cnt1;
    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; acceptance is judged with inputs settled, and the
    // word joins the expected queue only once it has been written.
    task automatic drive(input logic v, input logic sel, input logic [W-1:0] data);
        logic acc;
        bus.in_valid = v;
        bus.s        = sel;
        bus.d        = data;
        #2;
        acc = v & bus.in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            if (sel) exp_q1.push_back(data);
            else     exp_q0.push_back(data);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic clear_model();
        exp_q0.delete();
        exp_q1.delete();
        exp_cnt0 = '0;
        exp_cnt1 = '0;
    endtask

    // Monitor: transfers are decided at the negedge before the edge that makes them.
    always @(negedge clk) begin
        if (!rst) begin
            check("y0_valid", bus.y0_valid, exp_q0.size() != 0);
            check("cnt0", bus.cnt0, exp_cnt0);
            if (!bus.y0_valid) check("y0_idle", bus.y0, '0);
            else if (exp_q0.size() != 0) begin
                check("y0_data", bus.y0, exp_q0[0]);
                if (bus.y0_ready) begin
                    void'(exp_q0.pop_front());
                    exp_cnt0 = exp_cnt0 + 1'b1;
                end
            end
            check("y1_valid", bus.y1_valid, exp_q1.size() != 0);
            check("cnt1", bus.cnt1, exp_cnt1);
            if (!bus.y1_valid) check("y1_idle", bus.y1, '0);
            else if (exp_q1.size() != 0) begin
                check("y1_data", bus.y1, exp_q1[0]);
                if (bus.y1_ready) begin
                    void'(exp_q1.pop_front());
                    exp_cnt1 = exp_cnt1 + 1'b1;
                end
            end
        end
    end

    initial begin
        logic [C-1:0] base;
        n_checks = 0;
        n_fail   = 0;
        clear_model();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.s        = 1'b0;
        bus.d        = '0;
        bus.y0_ready = 1'b1;
        bus.y1_ready = 1'b1;
        #2;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_y0_valid", bus.y0_valid, 1'b0);
        check("rst_cnt0", bus.cnt0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1'b1);

        // Routing and one-cycle latency
        drive(1'b1, 1'b0, 8'hA5);
        check("route_y0_valid", bus.y0_valid, 1'b1);
        check("route_y0", bus.y0, 8'hA5);
        drive(1'b1, 1'b1, 8'h3C);
        check("route_y1_valid", bus.y1_valid, 1'b1);
        check("route_y1", bus.y1, 8'h3C);
        idle(2);
        check("route_cnt0", bus.cnt0, 8'd1);
        check("route_cnt1", bus.cnt1, 8'd1);

        // Mid-stream asynchronous reset with both FIFOs full
        bus.y0_ready = 1'b0;
        bus.y1_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h11);
        drive(1'b1, 1'b0, 8'h12);
        drive(1'b1, 1'b1, 8'h21);
        drive(1'b1, 1'b1, 8'h22);
        check("full_in_ready0", bus.in_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_y0_valid", bus.y0_valid, 1'b0);
        check("mid_rst_y1_valid", bus.y1_valid, 1'b0);
        check("mid_rst_y0", bus.y0, '0);
        check("mid_rst_y1", bus.y1, '0);
        check("mid_rst_cnt0", bus.cnt0, '0);
        check("mid_rst_cnt1", bus.cnt1, '0);
        check("mid_rst_in_ready", bus.in_ready, 1'b0);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.y0_ready = 1'b1;
        bus.y1_ready = 1'b1;
        #1;
        check("mid_rel_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Counter wrap on output 0
        for (int i = 0; i < 255; i++) drive(1'b1, 1'b0, W'(i));
        idle(3);
        check("wrap_cnt0_255", bus.cnt0, 8'd255);
        drive(1'b1, 1'b0, 8'hFF);
        idle(3);
        check("wrap_cnt0_0", bus.cnt0, 8'd0);
        check("wrap_cnt1", bus.cnt1, 8'd0);

        // Backpressure and select switch while refused
        bus.y0_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h01);
        drive(1'b1, 1'b0, 8'h02);
        bus.in_valid = 1'b1;
        bus.s        = 1'b0;
        bus.d        = 8'h03;
        #1;
        check("bp_in_ready_s0", bus.in_ready, 1'b0);
        bus.s = 1'b1;
        #1;
        check("bp_in_ready_s1", bus.in_ready, 1'b1);
        drive(1'b1, 1'b1, 8'h03);
        check("bp_y1", bus.y1, 8'h03);
        @(posedge clk);
        #1;
        bus.y0_ready = 1'b1;
        idle(4);
        check("bp_drained", bus.y0_valid, 1'b0);

        // Simultaneous push and pop on output 1
        bus.y1_ready = 1'b0;
        drive(1'b1, 1'b1, 8'h10);
        base = exp_cnt1;
        bus.y1_ready = 1'b1;
        drive(1'b1, 1'b1, 8'h20);
        check("pp_y1_valid", bus.y1_valid, 1'b1);
        check("pp_y1", bus.y1, 8'h20);
        idle(2);
        check("pp_cnt1", bus.cnt1, C'(base + 2));

        // Random soak
        for (int i = 0; i < 10000; i++) begin
            bus.y0_ready = 1'($urandom_range(0, 1));
            bus.y1_ready = 1'($urandom_range(0, 1));
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), W'($urandom_range(0, 255)));
        end
        bus.y0_ready = 1'b1;
        bus.y1_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) idle(1);
        idle(1);
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/demux12_stream.md
Name: demux12_stream

Overview:
- Registered 1-to-2 stream demultiplexer: the receiving-side counterpart of the team's 2:1 mux.
- Takes one valid/ready input stream and routes each accepted word to output 0 or 1, chosen by select `s` at acceptance time.
- Each output has a 2-entry FIFO, so one stalled consumer never corrupts or reorders the other path.
- Sits between a shared producer (e.g. the mux output bus) and two independent consumers.

Parameters:
- Size, 8, data word width in bits.
- CntW, 8, width of the per-output transfer counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word on d.
- in_ready  output  1  block can accept the word on d toward the currently selected output.
- s  input  1  routing select, sampled with d on acceptance: 0 -> output 0, 1 -> output 1.
- d  input  Size  input data word.
- y0_valid  output  1  output 0 head entry is valid.
- y0_ready  input  1  consumer 0 takes the head entry.
- y0  output  Size  output 0 head data.
- y1_valid  output  1  output 1 head entry is valid.
- y1_ready  input  1  consumer 1 takes the head entry.
- y1  output  Size  output 1 head data.
- cnt0  output  CntW  count of completed output-0 transfers.
- cnt1  output  CntW  count of completed output-1 transfers.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst=1, both FIFOs are emptied and cnt0/cnt1 are cleared. Reset values: y0_valid=y1_valid=0, y0=y1=0, cnt0=cnt1=0. in_ready is 1 when not in reset (both FIFOs empty). in_ready is 0 while rst=1.
- Input acceptance:
  - Accept = in_valid & in_ready.
  - in_ready = s ? !full1 : !full0. This is combinational from s and registered full flags only; it has no path from y0_ready/y1_ready.
  - A full FIFO refuses a push even if it pops in the same cycle (deliberate, to keep the timing path short).
- Push: on accept, d is written to the tail of FIFO[s]. The other FIFO is untouched.
- Latency: a word accepted at edge N is visible on yN/yN_valid after edge N, i.e. 1 cycle. There is no combinational d->y path.
- Output transfer:
  - A transfer occurs when yK_valid & yK_ready; the head is popped at that edge.
  - yK_valid = (countK != 0).
  - yK shows the head entry when valid and is driven to 0 when the FIFO is empty.
  - yK_ready while yK_valid=0 has no effect.
- FIFO occupancy (per output, 0..2):
  - Push only: +1. Pop only: -1. Push and pop in the same cycle (occupancy 1): occupancy stays 1, the new word becomes head after the old one leaves. Order is strictly FIFO.
  - Occupancy 0 with simultaneous push: no pop is possible; occupancy becomes 1.
- Counters:
  - cntK increments by 1 on each output-K transfer and wraps modulo 2^CntW (255 -> 0 at default).
  - Counters are not affected by input acceptance.
- Independence: both outputs may transfer in the same cycle. A stall on one output only blocks inputs that select that output.
- Reset mid-operation: all buffered words are discarded with no further transfers. After rst deasserts, behaviour is identical to power-up.
- Select changes while in_valid=1 and in_ready=0 are legal. Routing is decided only at the accepting edge.

Decomposition:
- Shared package or header holds:
  - Default Size=8 and CntW=8.
  - Localparam FIFO_DEPTH=2.
  - The pointer/occupancy width.
- One sub-module is natural: fifo2 (parameter Size). Ports: clk, rst, push, din, pop, dout, valid, full. Instantiate it twice.
- Routing logic and the counters stay in demux12_stream.

Test Plan:
- Reset: assert rst mid-stream with both FIFOs holding 2 words -> y0_valid=y1_valid=0, y0=y1=0, cnt0=cnt1=0 immediately, without waiting for a clock edge. After release, in_ready=1.
- Routing and latency: y0_ready=y1_ready=1; send d=8'hA5,s=0 then d=8'h3C,s=1 -> y0=A5 with y0_valid=1 one cycle after the first accept, y1=3C one cycle after the second. cnt0=1, cnt1=1.
- Full/backpressure: y0_ready=0; send 8'h01, 8'h02, 8'h03, all with s=0 -> first two accepted; in_ready=0 for the third. With s switched to 1 the same cycle, in_ready=1 and 8'h03 goes to y1. Release y0_ready -> y0 outputs 01 then 02.
- Simultaneous push/pop: output 1 holds one word 8'h10, y1_ready=1, push 8'h20 with s=1 in the same cycle -> occupancy stays 1, y1 shows 10 then 20, cnt1 advances by 2 total.
- Counter wrap: 256 back-to-back transfers on output 0 with y0_ready=1 -> cnt0 reads 255 and then wraps to 0; cnt1 remains 0.
- Random soak: random in_valid, s, y0_ready, y1_ready for 10k cycles against a scoreboard with two queues. Required: no loss, no reordering, and counters match the scoreboard.
